// File: rtl/conv_result_pkg.sv
// Shared types and requantization arithmetic for the convolution result drain.
package conv_result_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int unsigned REQ_WIDTH = 64;

  // Saturation bounds for a signed element of width dw
  function automatic logic signed [REQ_WIDTH-1:0] sat_max(input int unsigned dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [REQ_WIDTH-1:0] sat_min(input int unsigned dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

  function automatic int unsigned ch_width(input int unsigned d);
    return (d > 1) ? int'($clog2(d)) : 1;
  endfunction

  // Rounding arithmetic shift, optional ReLU, signed saturation; result fits in dw bits
  function automatic logic signed [REQ_WIDTH-1:0] requant(input logic signed [REQ_WIDTH-1:0] acc,
                                                          input int unsigned shift,
                                                          input logic relu,
                                                          input int unsigned dw);
    logic signed [REQ_WIDTH-1:0] rnd;
    logic signed [REQ_WIDTH-1:0] r;
    rnd = (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
    r   = (acc + rnd) >>> shift;
    if (relu && (r < 64'sd0)) r = 64'sd0;
    if (r > sat_max(dw)) r = sat_max(dw);
    else if (r < sat_min(dw)) r = sat_min(dw);
    return r;
  endfunction

endpackage

// File: rtl/conv_result_requant_drain_if.sv
// Write-lane bus and output stream of the convolution result drain.
interface conv_result_requant_drain_if
  import conv_result_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RESULT_W   = 6,
  parameter int unsigned RESULT_H   = 6,
  parameter int unsigned RESULT_D   = 8
);
  localparam int unsigned ACC_WIDTH             = 4 * DATA_WIDTH;
  localparam int unsigned N_PIX                 = RESULT_W * RESULT_H;
  localparam int unsigned RESULT_RAM_ADDR_WIDTH = $clog2(N_PIX);
  localparam int unsigned CH_WIDTH              = ch_width(RESULT_D);

  logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0] result_wraddress;
  logic [ACC_WIDTH*RESULT_D-1:0]             result_data_out;
  logic [RESULT_D-1:0]                       result_wren;
  logic                                      accept_rdy;
  logic                                      frame_done;
  logic                                      err_ovf;
  logic                                      out_val;
  logic                                      out_rdy;
  logic [DATA_WIDTH-1:0]                     out_data;
  logic [CH_WIDTH-1:0]                       out_ch;
  logic [RESULT_RAM_ADDR_WIDTH-1:0]          out_addr;
  logic                                      out_last;

  modport master (
    output result_wraddress, result_data_out, result_wren, out_rdy,
    input  accept_rdy, frame_done, err_ovf, out_val, out_data, out_ch, out_addr, out_last
  );

  modport slave (
    input  result_wraddress, result_data_out, result_wren, out_rdy,
    output accept_rdy, frame_done, err_ovf, out_val, out_data, out_ch, out_addr, out_last
  );
endinterface

// File: rtl/conv_result_requant_lane.sv
// One result lane: registered requantization of the accumulator plus address/strobe pipeline.
module conv_result_requant_lane
  import conv_result_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned RELU       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic                    wren_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [4*DATA_WIDTH-1:0] acc_i,
  output logic                    wren_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   data_o
);
  logic                  wren_d, wren_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;

  // Writes arriving while the frame is not being filled are dropped here
  always_comb begin
    wren_d = wren_i & en_i;
    addr_d = addr_i;
    data_d = DATA_WIDTH'(requant(64'($signed(acc_i)), SHIFT, (RELU != 0), DATA_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wren_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wren_q <= wren_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign wren_o = wren_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
endmodule

// File: rtl/conv_result_requant_drain.sv
// Captures per-filter accumulator streams into requantized banks and drains each frame channel-major.
module conv_result_requant_drain
  import conv_result_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RESULT_W   = 6,
  parameter int unsigned RESULT_H   = 6,
  parameter int unsigned RESULT_D   = 8,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned RELU       = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  conv_result_requant_drain_if.slave  bus
);
  localparam int unsigned ACC_WIDTH = 4 * DATA_WIDTH;
  localparam int unsigned N_PIX     = RESULT_W * RESULT_H;
  localparam int unsigned AW        = $clog2(N_PIX);
  localparam int unsigned CH_WIDTH  = ch_width(RESULT_D);
  localparam int unsigned CNT_WIDTH = $clog2(N_PIX + 1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   pix_cnt_q, pix_cnt_d;
  logic                   accept_rdy_q, accept_rdy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   err_ovf_q, err_ovf_d;
  logic [CH_WIDTH-1:0]    rd_ch_q, rd_ch_d;
  logic [AW-1:0]          rd_addr_q, rd_addr_d;
  logic                   rd_done_q, rd_done_d;
  logic                   out_val_q, out_val_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [CH_WIDTH-1:0]    out_ch_q, out_ch_d;
  logic [AW-1:0]          out_addr_q, out_addr_d;
  logic                   out_last_q, out_last_d;
  logic                   sk_val_q, sk_val_d;
  logic [DATA_WIDTH-1:0]  sk_data_q, sk_data_d;
  logic [CH_WIDTH-1:0]    sk_ch_q, sk_ch_d;
  logic [AW-1:0]          sk_addr_q, sk_addr_d;
  logic                   sk_last_q, sk_last_d;

  logic                                 fill_c;
  logic                                 issue_c;
  logic                                 xfer_c;
  logic                                 rd_last_c;
  logic [DATA_WIDTH-1:0]                rd_word_c;
  logic [RESULT_D-1:0]                  lane_wren;
  logic [RESULT_D-1:0][AW-1:0]          lane_addr;
  logic [RESULT_D-1:0][DATA_WIDTH-1:0]  lane_data;
  logic [RESULT_D-1:0][DATA_WIDTH-1:0]  bank_rd;

  assign fill_c = (state_q == FILL);

  for (genvar k = 0; k < int'(RESULT_D); k++) begin : gen_lane
    logic [DATA_WIDTH-1:0] mem_q [N_PIX];

    conv_result_requant_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (AW),
      .SHIFT      (SHIFT),
      .RELU       (RELU)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .en_i   (fill_c),
      .wren_i (bus.result_wren[k]),
      .addr_i (bus.result_wraddress[k*AW +: AW]),
      .acc_i  (bus.result_data_out[k*ACC_WIDTH +: ACC_WIDTH]),
      .wren_o (lane_wren[k]),
      .addr_o (lane_addr[k]),
      .data_o (lane_data[k])
    );

    // Result bank: write port from the lane, read port from the drain counters
    always_ff @(posedge clk) begin
      if (lane_wren[k]) mem_q[lane_addr[k]] <= lane_data[k];
    end

    assign bank_rd[k] = mem_q[rd_addr_q];
  end

  assign rd_word_c = bank_rd[rd_ch_q];
  assign rd_last_c = (rd_ch_q == CH_WIDTH'(RESULT_D - 1)) && (rd_addr_q == AW'(N_PIX - 1));

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    err_ovf_d    = err_ovf_q | (!fill_c && (|bus.result_wren));
    rd_ch_d      = rd_ch_q;
    rd_addr_d    = rd_addr_q;
    rd_done_d    = rd_done_q;
    out_val_d    = out_val_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_addr_d   = out_addr_q;
    out_last_d   = out_last_q;
    sk_val_d     = sk_val_q;
    sk_data_d    = sk_data_q;
    sk_ch_d      = sk_ch_q;
    sk_addr_d    = sk_addr_q;
    sk_last_d    = sk_last_q;
    issue_c      = 1'b0;
    xfer_c       = 1'b0;

    case (state_q)
      FILL: begin
        if (pix_cnt_q == CNT_WIDTH'(N_PIX)) begin
          state_d      = DRAIN;
          frame_done_d = 1'b1;
          pix_cnt_d    = '0;
        end else if (lane_wren[0]) begin
          pix_cnt_d = pix_cnt_q + CNT_WIDTH'(1);
        end
      end
      DRAIN: begin
        // Only read when the skid slot is guaranteed free when the data lands
        issue_c = !rd_done_q && (!sk_val_q || bus.out_rdy);
        xfer_c  = out_val_q && bus.out_rdy;
        if (issue_c) begin
          rd_done_d = rd_last_c;
          if (rd_addr_q == AW'(N_PIX - 1)) begin
            rd_addr_d = '0;
            rd_ch_d   = rd_ch_q + CH_WIDTH'(1);
          end else begin
            rd_addr_d = rd_addr_q + AW'(1);
          end
        end
        if (!out_val_q || xfer_c) begin
          if (sk_val_q) begin
            out_val_d  = 1'b1;
            out_data_d = sk_data_q;
            out_ch_d   = sk_ch_q;
            out_addr_d = sk_addr_q;
            out_last_d = sk_last_q;
            sk_val_d   = issue_c;
            if (issue_c) begin
              sk_data_d = rd_word_c;
              sk_ch_d   = rd_ch_q;
              sk_addr_d = rd_addr_q;
              sk_last_d = rd_last_c;
            end
          end else begin
            out_val_d = issue_c;
            if (issue_c) begin
              out_data_d = rd_word_c;
              out_ch_d   = rd_ch_q;
              out_addr_d = rd_addr_q;
              out_last_d = rd_last_c;
            end
          end
        end else if (issue_c) begin
          sk_val_d  = 1'b1;
          sk_data_d = rd_word_c;
          sk_ch_d   = rd_ch_q;
          sk_addr_d = rd_addr_q;
          sk_last_d = rd_last_c;
        end
        if (xfer_c && out_last_q) begin
          state_d   = FILL;
          pix_cnt_d = '0;
          rd_ch_d   = '0;
          rd_addr_d = '0;
          rd_done_d = 1'b0;
          out_val_d = 1'b0;
          sk_val_d  = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase

    accept_rdy_d = (state_d == FILL);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FILL;
      pix_cnt_q    <= '0;
      accept_rdy_q <= 1'b1;
      frame_done_q <= 1'b0;
      err_ovf_q    <= 1'b0;
      rd_ch_q      <= '0;
      rd_addr_q    <= '0;
      rd_done_q    <= 1'b0;
      out_val_q    <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_addr_q   <= '0;
      out_last_q   <= 1'b0;
      sk_val_q     <= 1'b0;
      sk_data_q    <= '0;
      sk_ch_q      <= '0;
      sk_addr_q    <= '0;
      sk_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      accept_rdy_q <= accept_rdy_d;
      frame_done_q <= frame_done_d;
      err_ovf_q    <= err_ovf_d;
      rd_ch_q      <= rd_ch_d;
      rd_addr_q    <= rd_addr_d;
      rd_done_q    <= rd_done_d;
      out_val_q    <= out_val_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_addr_q   <= out_addr_d;
      out_last_q   <= out_last_d;
      sk_val_q     <= sk_val_d;
      sk_data_q    <= sk_data_d;
      sk_ch_q      <= sk_ch_d;
      sk_addr_q    <= sk_addr_d;
      sk_last_q    <= sk_last_d;
    end
  end

  assign bus.accept_rdy = accept_rdy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err_ovf    = err_ovf_q;
  assign bus.out_val    = out_val_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_last   = out_last_q;
endmodule

// File: doc/conv_result_requant_drain.md
# conv_result_requant_drain

Downstream stage of the striped-BRAM 2-D convolution engine. It captures the RESULT_D parallel accumulator write streams produced by the convolution datapath, one lane per filter, each `4*DATA_WIDTH` bits wide. Each value is requantized to `DATA_WIDTH` with a rounding arithmetic shift, optional ReLU and signed saturation, then stored in per-channel result banks. Once a full frame has been written, the block drains the frame as a channel-major valid/ready stream and holds off the next frame through `accept_rdy`.

## Interface

Parameters:

- `DATA_WIDTH`, 8, output element width (signed).
- `RESULT_W`, 6, result plane width.
- `RESULT_H`, 6, result plane height.
- `RESULT_D`, 8, number of result channels (lanes).
- `SHIFT`, 8, requant right-shift amount, range 0..`4*DATA_WIDTH-1`.
- `RELU`, 1, 1 clamps negative results to 0.
- Derived, not set manually:
  - `ACC_WIDTH` = `4*DATA_WIDTH`.
  - `N_PIX` = `RESULT_W*RESULT_H`.
  - `RESULT_RAM_ADDR_WIDTH` = `$clog2(N_PIX)`.
  - `CH_WIDTH` = `max(1,$clog2(RESULT_D))`.

Ports:

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `result_wraddress` in `RESULT_RAM_ADDR_WIDTH*RESULT_D`: per-lane write address; lane k occupies slice k.
- `result_data_out` in `ACC_WIDTH*RESULT_D`: per-lane signed accumulator.
- `result_wren` in `RESULT_D`: per-lane write strobe.
- `accept_rdy` out 1: high while in FILL; upstream gates its frame-start `val_in` with it.
- `frame_done` out 1: one-cycle pulse when FILL→DRAIN.
- `err_ovf` out 1: sticky; set when a write arrives outside FILL.
- `out_val` out 1, `out_rdy` in 1: output handshake.
- `out_data` out `DATA_WIDTH`: requantized element.
- `out_ch` out `CH_WIDTH`: channel of `out_data`.
- `out_addr` out `RESULT_RAM_ADDR_WIDTH`: pixel address, `w + h*RESULT_W`.
- `out_last` out 1: high on the final element of the frame.

## Operation

- **Requant, per lane, registered (1 cycle):**
  - `r = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT`, computed at `ACC_WIDTH+1` bits so the rounding add never overflows.
  - If `RELU` and `r<0`, then `r=0`.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- **Banks:** RESULT_D simple-dual-port banks, `N_PIX` x `DATA_WIDTH`. The registered lane k writes bank k at its registered address. Lanes are independent; a lane with wren low writes nothing.
- **FSM states:** FILL, DRAIN.
- **FILL:**
  - `pix_cnt` increments on each registered lane-0 write.
  - When it reaches `N_PIX`, the next state is DRAIN and `frame_done` pulses for one cycle.
  - Lane 0 is the frame-progress reference, because all lanes share one controller upstream.
- **Writes outside FILL:** a wren on any lane outside FILL is dropped (bank untouched) and sets `err_ovf`. `err_ovf` clears only on reset.
- **DRAIN order:** channel-major, ch 0..RESULT_D-1, then addr 0..`N_PIX-1`.
  - Bank read latency is 1 cycle.
  - A 1-entry output register plus a 1-entry skid register sustain 1 element/cycle while `out_rdy` is high.
- **DRAIN completion:** after the handshake of the element carrying `out_last`, the next state is FILL, `pix_cnt`=0 and `accept_rdy`=1.
- **Reset values:**
  - Outputs: `accept_rdy`=1, `out_val`=0, `out_data`=0, `out_ch`=0, `out_addr`=0, `out_last`=0, `frame_done`=0, `err_ovf`=0.
  - Internal: state FILL, all counters 0.
  - Bank contents are undefined.

## Timing

- The lane write sampled at edge T lands in its bank at edge T+1.
- If the `N_PIX`-th lane-0 write is sampled at T:
  - `frame_done`=1 and state=DRAIN in cycle T+2.
  - First read issues at T+2.
  - `out_val`=1 at T+3.
  - `accept_rdy` falls at T+2.
- Handshake rules:
  - A transfer occurs when `out_val && out_rdy`.
  - While `out_val && !out_rdy`, `out_data`, `out_ch`, `out_addr` and `out_last` are held stable.
  - `out_val` never drops without a transfer.
- With `out_rdy` tied high, the drain takes exactly `RESULT_D*N_PIX` consecutive cycles of `out_val`=1.
- Reset low at any cycle, including mid-DRAIN or mid-transfer: at the next edge all state takes its reset values, and a partially drained frame is discarded.
- Lane-0 write in the same cycle DRAIN exits: the write is dropped and `err_ovf` is set, because `accept_rdy` was low.

## Structure

- **Shared package `conv_result_pkg`:**
  - FSM state enum `{FILL, DRAIN}`.
  - Function `requant(acc, shift, relu)` returning `DATA_WIDTH`.
  - Saturation bound constants.
- **Sub-module `conv_result_requant_lane`:** registered requant plus addr/wren pipeline, instantiated RESULT_D times via generate.
- **Top level:** banks, FSM, `pix_cnt`, drain counters and the skid buffer.

## Test plan

Configuration: D=2, W=H=2, SHIFT=4, RELU=0 unless stated.

- **Rounding and saturation:** lane 0 accumulators 24, -24, 5000, -5000 at addr 0..3; lane 1 = 0. Drained ch0 must read 2, -1, 127, -128, and ch1 must read 0,0,0,0.
- **ReLU:** RELU=1, same stimulus as rounding and saturation. Drained ch0 must read 2, 0, 127, 0.
- **Ordering and latency:** `out_rdy`=1, final write at T.
  - `out_val` rises at T+3 and stays high for 8 cycles.
  - `(out_ch,out_addr)` runs (0,0)..(0,3),(1,0)..(1,3).
  - `out_last` is high only on (1,3).
  - `accept_rdy` returns to 1 on the cycle after that transfer.
- **Backpressure:** `out_rdy` toggles 1,0,0,1 repeating. Every element is delivered exactly once, in order, and outputs are stable during stalls.
- **Overflow:** inject a lane-1 wren during DRAIN. `err_ovf`=1 and the drained ch1 values are unchanged.
- **Reset mid-drain:** assert reset after 3 transfers. Next cycle `out_val`=0, `accept_rdy`=1 and `err_ovf`=0; a following full frame drains correctly.
